multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max wait cycles for Mem_Ready_i before trap, range 1..255.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; low forces IDLE immediately.
REQ-004 OP_i  in  7  opcode field of instruction register, sampled in DECODE.
REQ-005 Branch_Taken_i  in  1  ALU branch-compare result, valid in BRANCH.
REQ-006 Mem_Ready_i  in  1  memory handshake; access completes in the cycle it is high.
REQ-007 PC_Write_o  out  1  PC register load enable.
REQ-008 IR_Write_o  out  1  instruction register load enable.
REQ-009 IorD_o  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-010 Mem_Read_o / Mem_Write_o  out  1 each  memory strobes, held until Mem_Ready_i.
REQ-011 Reg_Write_o  out  1  register file write enable; Mem_to_Reg_o out 1 selects data-memory (1) or ALU (0).
REQ-012 ALU_Src_A_o  out  2  00 PC, 01 rs1, 10 zero; ALU_Src_B_o out 2  00 rs2, 01 immediate, 10 constant 4.
REQ-013 ALU_Op_o  out  3  000 R, 001 I/load/store/jalr, 010 U, 100 B, 101 J, 110 PC+4 add.
REQ-014 PC_Src_o  out  2  00 ALU output, 01 ALU result register (branch/jump target), 10 trap vector.
REQ-015 Illegal_o  out  1  high in TRAP; State_o out 4 current state encoding for debug.

Function
REQ-016 States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, WB_ALU, BRANCH, JAL, JALR, LUI, TRAP; all outputs Moore-decoded from state.
REQ-017 IDLE: all outputs 0; unconditional transition to FETCH next cycle.
REQ-018 FETCH: IorD=0, Mem_Read=1, ALU A=PC, B=4, ALU_Op=110; stays until Mem_Ready_i=1, then IR_Write=1, PC_Write=1, PC_Src=00 in that cycle and goes to DECODE.
REQ-019 DECODE: ALU A=PC, B=imm, ALU_Op=110 (target precompute); next state by OP_i: 0x33 EXEC_R, 0x13 EXEC_I, 0x03/0x23 MEM_ADDR, 0x63 BRANCH, 0x6F JAL, 0x67 JALR, 0x37 LUI, else TRAP.
REQ-020 EXEC_R: A=rs1, B=rs2, ALU_Op=000 -> WB_ALU; EXEC_I: A=rs1, B=imm, ALU_Op=001 -> WB_ALU.
REQ-021 MEM_ADDR: A=rs1, B=imm, ALU_Op=001 -> MEM_RD if opcode latched in DECODE was 0x03, else MEM_WR.
REQ-022 MEM_RD: IorD=1, Mem_Read=1 until Mem_Ready_i -> WB_MEM; MEM_WR: IorD=1, Mem_Write=1 until Mem_Ready_i -> FETCH.
REQ-023 WB_MEM: Reg_Write=1, Mem_to_Reg=1 -> FETCH; WB_ALU: Reg_Write=1, Mem_to_Reg=0 -> FETCH.
REQ-024 BRANCH: A=rs1, B=rs2, ALU_Op=100; PC_Write=Branch_Taken_i, PC_Src=01 -> FETCH.
REQ-025 JAL: PC_Write=1, PC_Src=01, Reg_Write=1 (link = PC), ALU_Op=101 -> FETCH; JALR: A=rs1, B=imm, ALU_Op=001, PC_Write=1, PC_Src=00, Reg_Write=1 -> FETCH.
REQ-026 LUI: A=zero, B=imm, ALU_Op=010, Reg_Write=1 -> FETCH.
REQ-027 Opcode SHALL be latched into an internal register on the DECODE cycle; later states use only the latch.
REQ-028 Wait counter (8 bit) clears on entry to FETCH/MEM_RD/MEM_WR, increments each cycle Mem_Ready_i=0 there; reaching MEM_TIMEOUT -> TRAP.
REQ-029 TRAP: Illegal_o=1, PC_Write=1, PC_Src=10 for one cycle, then FETCH.
REQ-030 Mem_Ready_i while no memory strobe is high SHALL be ignored.
REQ-031 Mem_Ready_i high on the same cycle the counter reaches MEM_TIMEOUT: completion wins, no trap.

Reset
REQ-032 reset low: state IDLE, opcode latch 0, wait counter 0, all outputs 0, asynchronously, including mid-access.
REQ-033 First FETCH occurs the second rising edge after reset deasserts.

Structure
REQ-034 Opcode constants, state encoding and ALU_Op/mux-select codes SHALL live in a shared package reused by the single-cycle Control.
REQ-035 Wait counter SHALL be a sub-module mem_wait_timer (clear, count, limit, expired).

Verification
REQ-036 Reset release, Mem_Ready_i=1 always, OP_i=0x33 -> IDLE, FETCH, DECODE, EXEC_R, WB_ALU with Reg_Write=1 only in WB_ALU.
REQ-037 OP_i=0x03, Mem_Ready_i delayed 3 cycles in MEM_RD -> Mem_Read held 4 cycles, then WB_MEM with Mem_to_Reg=1.
REQ-038 OP_i=0x63, Branch_Taken_i=0 then 1 -> PC_Write=0 then 1 in BRANCH, PC_Src=01.
REQ-039 OP_i=0x7F -> TRAP after DECODE, Illegal_o=1, PC_Src=10 one cycle, then FETCH.
REQ-040 Mem_Ready_i held 0 in FETCH with MEM_TIMEOUT=15 -> TRAP after exactly 15 wait cycles; Ready on 15th -> no trap.
REQ-041 reset pulsed low during MEM_WR -> Mem_Write_o drops immediately, State_o=IDLE.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared control encodings: opcodes, FSM state codes, ALU op and mux selects.
// Reused by both the multicycle and the single-cycle control units.
package multicycle_control_pkg;

    localparam logic [6:0] OPC_R      = 7'h33;
    localparam logic [6:0] OPC_I      = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_LUI    = 7'h37;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WR   = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_WB_ALU   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JAL      = 4'd11;
    localparam logic [3:0] S_JALR     = 4'd12;
    localparam logic [3:0] S_LUI      = 4'd13;
    localparam logic [3:0] S_TRAP     = 4'd14;

    localparam logic [2:0] ALU_R   = 3'b000;
    localparam logic [2:0] ALU_I   = 3'b001;
    localparam logic [2:0] ALU_U   = 3'b010;
    localparam logic [2:0] ALU_B   = 3'b100;
    localparam logic [2:0] ALU_J   = 3'b101;
    localparam logic [2:0] ALU_PC4 = 3'b110;

    localparam logic [1:0] SRCA_PC   = 2'b00;
    localparam logic [1:0] SRCA_RS1  = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_TGT  = 2'b01;
    localparam logic [1:0] PCS_TRAP = 2'b10;

    function automatic logic [3:0] decode_next(input logic [6:0] op);
        case (op)
            OPC_R:              return S_EXEC_R;
            OPC_I:              return S_EXEC_I;
            OPC_LOAD,
            OPC_STORE:          return S_MEM_ADDR;
            OPC_BRANCH:         return S_BRANCH;
            OPC_JAL:            return S_JAL;
            OPC_JALR:           return S_JALR;
            OPC_LUI:            return S_LUI;
            default:            return S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Memory wait counter: flags expiry on the cycle the limit would be reached.
module mem_wait_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       count,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= 8'd0;
        else if (clear)
            cnt <= 8'd0;
        else if (count)
            cnt <= cnt + 8'd1;
    end

    assign expired = count && (cnt >= limit - 8'd1);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM with memory handshake timeout and trap.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] OP_i,
    input  logic       Branch_Taken_i,
    input  logic       Mem_Ready_i,
    output logic       PC_Write_o,
    output logic       IR_Write_o,
    output logic       IorD_o,
    output logic       Mem_Read_o,
    output logic       Mem_Write_o,
    output logic       Reg_Write_o,
    output logic       Mem_to_Reg_o,
    output logic [1:0] ALU_Src_A_o,
    output logic [1:0] ALU_Src_B_o,
    output logic [2:0] ALU_Op_o,
    output logic [1:0] PC_Src_o,
    output logic       Illegal_o,
    output logic [3:0] State_o
);

    logic [3:0] state;
    logic [3:0] next;
    logic [6:0] op_q;
    logic       armed;
    logic       waiting;
    logic       expired;

    assign waiting = (state == S_FETCH) || (state == S_MEM_RD)
                  || (state == S_MEM_WR);

    mem_wait_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (next != state),
        .count   (waiting && !Mem_Ready_i),
        .limit   (8'(MEM_TIMEOUT)),
        .expired (expired)
    );

    // IDLE is held through the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            op_q  <= 7'd0;
            armed <= 1'b0;
        end else begin
            state <= next;
            armed <= 1'b1;
            if (state == S_DECODE)
                op_q <= OP_i;
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:     if (armed) next = S_FETCH;
            S_FETCH:    if (Mem_Ready_i) next = S_DECODE;
                        else if (expired) next = S_TRAP;
            S_DECODE:   next = decode_next(OP_i);
            S_EXEC_R,
            S_EXEC_I:   next = S_WB_ALU;
            S_MEM_ADDR: next = (op_q == OPC_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (Mem_Ready_i) next = S_WB_MEM;
                        else if (expired) next = S_TRAP;
            S_MEM_WR:   if (Mem_Ready_i) next = S_FETCH;
                        else if (expired) next = S_TRAP;
            default:    next = S_FETCH;
        endcase
    end

    always_comb begin
        PC_Write_o   = 1'b0;
        IR_Write_o   = 1'b0;
        IorD_o       = 1'b0;
        Mem_Read_o   = 1'b0;
        Mem_Write_o  = 1'b0;
        Reg_Write_o  = 1'b0;
        Mem_to_Reg_o = 1'b0;
        ALU_Src_A_o  = SRCA_PC;
        ALU_Src_B_o  = SRCB_RS2;
        ALU_Op_o     = ALU_R;
        PC_Src_o     = PCS_ALU;
        Illegal_o    = 1'b0;
        case (state)
            S_FETCH: begin
                Mem_Read_o  = 1'b1;
                ALU_Src_B_o = SRCB_FOUR;
                ALU_Op_o    = ALU_PC4;
                IR_Write_o  = Mem_Ready_i;
                PC_Write_o  = Mem_Ready_i;
            end
            S_DECODE: begin
                ALU_Src_B_o = SRCB_IMM;
                ALU_Op_o    = ALU_PC4;
            end
            S_EXEC_R: ALU_Src_A_o = SRCA_RS1;
            S_EXEC_I, S_MEM_ADDR: begin
                ALU_Src_A_o = SRCA_RS1;
                ALU_Src_B_o = SRCB_IMM;
                ALU_Op_o    = ALU_I;
            end
            S_MEM_RD: begin
                IorD_o     = 1'b1;
                Mem_Read_o = 1'b1;
            end
            S_MEM_WR: begin
                IorD_o      = 1'b1;
                Mem_Write_o = 1'b1;
            end
            S_WB_MEM: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = 1'b1;
            end
            S_WB_ALU: Reg_Write_o = 1'b1;
            S_BRANCH: begin
                ALU_Src_A_o = SRCA_RS1;
                ALU_Op_o    = ALU_B;
                PC_Write_o  = Branch_Taken_i;
                PC_Src_o    = PCS_TGT;
            end
            S_JAL: begin
                PC_Write_o  = 1'b1;
                PC_Src_o    = PCS_TGT;
                Reg_Write_o = 1'b1;
                ALU_Op_o    = ALU_J;
            end
            S_JALR: begin
                ALU_Src_A_o = SRCA_RS1;
                ALU_Src_B_o = SRCB_IMM;
                ALU_Op_o    = ALU_I;
                PC_Write_o  = 1'b1;
                Reg_Write_o = 1'b1;
            end
            S_LUI: begin
                ALU_Src_A_o = SRCA_ZERO;
                ALU_Src_B_o = SRCB_IMM;
                ALU_Op_o    = ALU_U;
                Reg_Write_o = 1'b1;
            end
            S_TRAP: begin
                Illegal_o  = 1'b1;
                PC_Write_o = 1'b1;
                PC_Src_o   = PCS_TRAP;
            end
            default: ;
        endcase
    end

    assign State_o = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench: per-instruction expected cycle sequences vs. the control FSM.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    localparam int T = 15;

    logic       clk;
    logic       reset;
    logic [6:0] OP_i;
    logic       Branch_Taken_i;
    logic       Mem_Ready_i;
    logic       PC_Write_o, IR_Write_o, IorD_o, Mem_Read_o, Mem_Write_o;
    logic       Reg_Write_o, Mem_to_Reg_o, Illegal_o;
    logic [1:0] ALU_Src_A_o, ALU_Src_B_o, PC_Src_o;
    logic [2:0] ALU_Op_o;
    logic [3:0] State_o;

    typedef struct packed {
        logic       pcw, irw, iord, mrd, mwr, rw, m2r;
        logic [1:0] a, b;
        logic [2:0] op;
        logic [1:0] pcs;
        logic       ill;
    } ov_t;

    typedef struct {
        logic       rdy;
        logic [6:0] opc;
        logic       tk;
        logic [3:0] st;
        ov_t        ov;
    } cyc_t;

    cyc_t q[$];
    ov_t  dut_ov;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    multicycle_control #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .OP_i(OP_i),
        .Branch_Taken_i(Branch_Taken_i), .Mem_Ready_i(Mem_Ready_i),
        .PC_Write_o(PC_Write_o), .IR_Write_o(IR_Write_o),
        .IorD_o(IorD_o), .Mem_Read_o(Mem_Read_o),
        .Mem_Write_o(Mem_Write_o), .Reg_Write_o(Reg_Write_o),
        .Mem_to_Reg_o(Mem_to_Reg_o), .ALU_Src_A_o(ALU_Src_A_o),
        .ALU_Src_B_o(ALU_Src_B_o), .ALU_Op_o(ALU_Op_o),
        .PC_Src_o(PC_Src_o), .Illegal_o(Illegal_o), .State_o(State_o)
    );

    assign dut_ov = {PC_Write_o, IR_Write_o, IorD_o, Mem_Read_o,
                     Mem_Write_o, Reg_Write_o, Mem_to_Reg_o,
                     ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, PC_Src_o,
                     Illegal_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    function automatic ov_t mk(logic pcw, logic irw, logic iord,
                               logic mrd, logic mwr, logic rw,
                               logic m2r, logic [1:0] a, logic [1:0] b,
                               logic [2:0] op, logic [1:0] pcs,
                               logic ill);
        ov_t o;
        o.pcw = pcw; o.irw = irw; o.iord = iord; o.mrd = mrd;
        o.mwr = mwr; o.rw = rw; o.m2r = m2r; o.a = a; o.b = b;
        o.op = op; o.pcs = pcs; o.ill = ill;
        return o;
    endfunction

    task automatic push(input logic [3:0] st, input ov_t ov,
                        input logic rdy, input logic [6:0] opc,
                        input logic tk);
        cyc_t c;
        c.st = st; c.ov = ov; c.rdy = rdy; c.opc = opc; c.tk = tk;
        q.push_back(c);
    endtask

    task automatic push_trap();
        push(S_TRAP, mk(1,0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b10,1),
             rb(), rop(), rb());
    endtask

    // Memory data phase: d idle cycles, then ready or a timeout trap.
    task automatic mem(input logic load, input int d);
        ov_t m;
        logic [3:0] st;
        st = load ? S_MEM_RD : S_MEM_WR;
        m = mk(0,0,1,load,!load,0,0,2'b00,2'b00,3'b000,2'b00,0);
        for (int i = 0; i < d && i < T; i++) push(st, m, 0, rop(), rb());
        if (d >= T) begin
            push_trap();
            return;
        end
        push(st, m, 1, rop(), rb());
        if (load)
            push(S_WB_MEM, mk(0,0,0,0,0,1,1,2'b00,2'b00,3'b000,2'b00,0),
                 rb(), rop(), rb());
    endtask

    task automatic plan(input logic [6:0] op, input int df,
                        input int dm, input logic tk);
        ov_t f;
        ov_t wb;
        f = mk(0,0,0,1,0,0,0,2'b00,2'b10,3'b110,2'b00,0);
        wb = mk(0,0,0,0,0,1,0,2'b00,2'b00,3'b000,2'b00,0);
        for (int i = 0; i < df && i < T; i++) push(S_FETCH, f, 0, rop(), rb());
        if (df >= T) begin
            push_trap();
            return;
        end
        f.pcw = 1'b1;
        f.irw = 1'b1;
        push(S_FETCH, f, 1, rop(), rb());
        push(S_DECODE, mk(0,0,0,0,0,0,0,2'b00,2'b01,3'b110,2'b00,0),
             rb(), op, rb());
        case (op)
            7'h33: begin
                push(S_EXEC_R, mk(0,0,0,0,0,0,0,2'b01,2'b00,3'b000,2'b00,0),
                     rb(), rop(), rb());
                push(S_WB_ALU, wb, rb(), rop(), rb());
            end
            7'h13: begin
                push(S_EXEC_I, mk(0,0,0,0,0,0,0,2'b01,2'b01,3'b001,2'b00,0),
                     rb(), rop(), rb());
                push(S_WB_ALU, wb, rb(), rop(), rb());
            end
            7'h03, 7'h23: begin
                push(S_MEM_ADDR,
                     mk(0,0,0,0,0,0,0,2'b01,2'b01,3'b001,2'b00,0),
                     rb(), rop(), rb());
                mem(op == 7'h03, dm);
            end
            7'h63: push(S_BRANCH,
                        mk(tk,0,0,0,0,0,0,2'b01,2'b00,3'b100,2'b01,0),
                        rb(), rop(), tk);
            7'h6F: push(S_JAL, mk(1,0,0,0,0,1,0,2'b00,2'b00,3'b101,2'b01,0),
                        rb(), rop(), rb());
            7'h67: push(S_JALR, mk(1,0,0,0,0,1,0,2'b01,2'b01,3'b001,2'b00,0),
                        rb(), rop(), rb());
            7'h37: push(S_LUI, mk(0,0,0,0,0,1,0,2'b10,2'b01,3'b010,2'b00,0),
                        rb(), rop(), rb());
            default: push_trap();
        endcase
    endtask

    task automatic play();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            Mem_Ready_i = c.rdy;
            OP_i = c.opc;
            Branch_Taken_i = c.tk;
            #1;
            chk($sformatf("state@%0d", cyc), 32'(State_o), 32'(c.st));
            chk($sformatf("outs@%0d", cyc), 32'(dut_ov), 32'(c.ov));
            cyc++;
            @(negedge clk);
        end
    endtask

    function automatic logic [6:0] pick_op();
        case ($urandom_range(0, 9))
            0: return 7'h33;
            1: return 7'h13;
            2: return 7'h03;
            3: return 7'h23;
            4: return 7'h63;
            5: return 7'h6F;
            6: return 7'h67;
            7: return 7'h37;
            8: return 7'h7F;
            default: return rop();
        endcase
    endfunction

    function automatic int pick_d();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 14) return int'($urandom_range(0, 3));
        if (r < 17) return T - 1;
        if (r < 19) return T;
        return T + 3;
    endfunction

    task automatic idle2();
        push(S_IDLE, '0, rb(), rop(), rb());
        push(S_IDLE, '0, rb(), rop(), rb());
    endtask

    initial begin
        reset = 1'b0;
        OP_i = 7'h33;
        Branch_Taken_i = 1'b0;
        Mem_Ready_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state", 32'(State_o), 32'(S_IDLE));
        chk("rst_outs", 32'(dut_ov), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle2();
        plan(7'h33, 0, 0, 0);
        plan(7'h03, 0, 3, 0);
        plan(7'h63, 0, 0, 0);
        plan(7'h63, 0, 0, 1);
        plan(7'h7F, 0, 0, 0);
        plan(7'h13, T, 0, 0);
        plan(7'h13, T - 1, 0, 0);
        plan(7'h23, 1, T, 0);
        plan(7'h23, 2, T - 1, 0);
        for (int n = 0; n < 250; n++)
            plan(pick_op(), pick_d(), pick_d(), rb());
        plan(7'h23, 0, 0, 0);
        void'(q.pop_back());
        push(S_MEM_WR, mk(0,0,1,0,1,0,0,2'b00,2'b00,3'b000,2'b00,0),
             0, rop(), rb());
        play();
        Mem_Ready_i = 1'b0;
        #1;
        chk("mwr_before_rst", 32'(Mem_Write_o), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mwr_async_rst", 32'(Mem_Write_o), 32'd0);
        chk("state_async_rst", 32'(State_o), 32'(S_IDLE));
        chk("outs_async_rst", 32'(dut_ov), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        idle2();
        plan(7'h37, T - 1, 0, 0);
        plan(7'h6F, T, 0, 0);
        plan(7'h67, 0, 0, 0);
        play();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
